// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings, FSM states and the misalignment check shared by the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  function automatic logic misaligned(input logic [2:0] f3, input logic we, input logic [1:0] a);
    case (f3)
      F3_B:    return 1'b0;
      F3_H:    return a == 2'b11;
      F3_W:    return a != 2'b00;
      F3_BU:   return we;
      F3_HU:   return we | (a == 2'b11);
      default: return 1'b1;
    endcase
  endfunction
endpackage

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: sign/zero extends a right-aligned RAM load word according to funct3
import lsu_pkg::*;
module lsu_load_ext (
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] ext
);
  assign ext = funct3 == F3_B  ? {{24{raw[7]}}, raw[7:0]}   :
               funct3 == F3_H  ? {{16{raw[15]}}, raw[15:0]} :
               funct3 == F3_BU ? {24'b0, raw[7:0]}          :
               funct3 == F3_HU ? {16'b0, raw[15:0]}         : raw;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store initiator to a byte-enabled RAM; optional trap via LSU_MISALIGN_TRAP_EN
import lsu_pkg::*;
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [4:0]            resp_rd,
  output logic                  resp_err,
  output logic [2:0]            mem_rwtyp,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  output logic                  mem_rden,
  input  logic [DATA_WIDTH-1:0] mem_q
);
  state_t state, nxt;
  logic we_q;
  logic bad;
  logic [31:0] ext;
  lsu_load_ext u_ext (.funct3(mem_rwtyp), .raw(mem_q), .ext(ext));
`ifdef LSU_MISALIGN_TRAP_EN
  assign bad = misaligned(mem_rwtyp, we_q, mem_addr[1:0]);
`else
  assign bad = 1'b0;
`endif
  // state register; reset aborts any in-flight access
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= nxt;
  end
  // next state and strobes; RAM strobes only ever fire in ISSUE and are suppressed for trapped requests
  always_comb begin
    nxt = state;
    req_ready = 1'b0;
    resp_valid = 1'b0;
    mem_wren = 1'b0;
    mem_rden = 1'b0;
    case (state)
      IDLE: begin
        req_ready = rstn;
        nxt = (req_valid && rstn) ? ISSUE : IDLE;
      end
      ISSUE: begin
        mem_wren = we_q & ~bad;
        mem_rden = ~we_q & ~bad;
        nxt = (we_q || bad) ? RESP : CAPTURE;
      end
      CAPTURE: nxt = RESP;
      default: begin
        resp_valid = 1'b1;
        nxt = resp_ready ? IDLE : RESP;
      end
    endcase
  end
  // request capture on accept, error latch in ISSUE, extended load data in CAPTURE
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we_q <= 1'b0;
      resp_rd <= '0;
      mem_rwtyp <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else begin
      if (req_valid && req_ready) begin
        we_q <= req_we;
        resp_rd <= req_rd;
        mem_rwtyp <= req_funct3;
        mem_addr <= req_addr;
        mem_data <= req_wdata;
        resp_rdata <= '0;
        resp_err <= 1'b0;
      end
      if (state == ISSUE) resp_err <= bad;
      if (state == CAPTURE) resp_rdata <= ext;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit against a small byte-lane RAM model
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0] req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [4:0] req_rd = '0;
  logic resp_valid, resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic [4:0] resp_rd;
  logic resp_err;
  logic [2:0] mem_rwtyp;
  logic [31:0] mem_addr, mem_data;
  logic mem_wren, mem_rden;
  logic [31:0] mem_q = '0;
  logic [31:0] ram [0:63];
  int n_cmp = 0, n_err = 0;

  mem_access_unit dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_rd(resp_rd), .resp_err(resp_err),
    .mem_rwtyp(mem_rwtyp), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  // RAM: lane-shifted writes, right-aligned zero-extended reads one cycle after rden
  always @(posedge clk) begin
    int sh;
    logic [31:0] m, rv;
    sh = 8 * int'(mem_addr[1:0]);
    m = mem_rwtyp[1] ? 32'hFFFF_FFFF : mem_rwtyp[0] ? 32'h0000_FFFF : 32'h0000_00FF;
    rv = ram[mem_addr[7:2]] >> sh;
    if (mem_wren) ram[mem_addr[7:2]] = (ram[mem_addr[7:2]] & ~(m << sh)) | ((mem_data & m) << sh);
    mem_q <= mem_rden ? (rv & m) : 32'h0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    req(1'b1, f3, a, wd, rd);
    @(negedge clk);
    chk("st_wren_t1", {31'b0, mem_wren}, 32'd1);
    chk("st_rden_t1", {31'b0, mem_rden}, 32'd0);
    chk("st_rwtyp", {29'b0, mem_rwtyp}, {29'b0, f3});
    chk("st_addr", mem_addr, a);
    chk("st_data", mem_data, wd);
    chk("st_rvalid_t1", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("st_wren_t2", {31'b0, mem_wren}, 32'd0);
    chk("st_rvalid_t2", {31'b0, resp_valid}, 32'd1);
    chk("st_rdata", resp_rdata, 32'd0);
    chk("st_rd", {27'b0, resp_rd}, {27'b0, rd});
    chk("st_err", {31'b0, resp_err}, 32'd0);
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd, input logic [31:0] exp);
    req(1'b0, f3, a, 32'h0, rd);
    @(negedge clk);
    chk("ld_rden_t1", {31'b0, mem_rden}, 32'd1);
    chk("ld_wren_t1", {31'b0, mem_wren}, 32'd0);
    chk("ld_rwtyp", {29'b0, mem_rwtyp}, {29'b0, f3});
    chk("ld_addr", mem_addr, a);
    @(negedge clk);
    chk("ld_rden_t2", {31'b0, mem_rden}, 32'd0);
    chk("ld_rvalid_t2", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("ld_rvalid_t3", {31'b0, resp_valid}, 32'd1);
    chk("ld_rdata", resp_rdata, exp);
    chk("ld_rd", {27'b0, resp_rd}, {27'b0, rd});
    chk("ld_err", {31'b0, resp_err}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready_low", {31'b0, req_ready}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_strobes", {30'b0, mem_wren, mem_rden}, 32'd0);
    chk("rst_err", {31'b0, resp_err}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    store(3'b010, 32'h100, 32'hDEAD_BEEF, 5'd3);
    load(3'b010, 32'h100, 5'd4, 32'hDEAD_BEEF);
    store(3'b010, 32'h100, 32'h0000_8000, 5'd5);
    load(3'b000, 32'h101, 5'd6, 32'hFFFF_FF80);
    load(3'b100, 32'h101, 5'd7, 32'h0000_0080);
    store(3'b010, 32'h100, 32'hF00D_0000, 5'd8);
    load(3'b001, 32'h102, 5'd12, 32'hFFFF_F00D);
    load(3'b101, 32'h102, 5'd13, 32'h0000_F00D);
    store(3'b000, 32'h100, 32'h0000_007F, 5'd14);
    load(3'b000, 32'h100, 5'd15, 32'h0000_007F);
    store(3'b001, 32'h102, 32'h0000_8001, 5'd16);
    load(3'b001, 32'h102, 5'd17, 32'hFFFF_8001);
    load(3'b010, 32'h100, 5'd18, 32'h8001_007F);
    // response backpressure: response must hold and no new request may be taken
    @(negedge clk);
    resp_ready = 1'b0;
    req(1'b0, 3'b000, 32'h100, 32'h0, 5'd9);
    @(negedge clk);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h200; req_wdata = 32'h1234_5678; req_rd = 5'd20;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rvalid", {31'b0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, 32'h0000_007F);
      chk("hold_rd", {27'b0, resp_rd}, 32'd9);
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
      chk("hold_strobes", {30'b0, mem_wren, mem_rden}, 32'd0);
      chk("hold_addr", mem_addr, 32'h100);
    end
    resp_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("release_rvalid", {31'b0, resp_valid}, 32'd0);
    chk("release_req_ready", {31'b0, req_ready}, 32'd1);
    // misaligned word load
    req(1'b0, 3'b010, 32'h102, 32'h0, 5'd10);
    @(negedge clk);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_rden", {31'b0, mem_rden}, 32'd0);
    chk("mis_wren", {31'b0, mem_wren}, 32'd0);
    @(negedge clk);
    chk("mis_rvalid", {31'b0, resp_valid}, 32'd1);
    chk("mis_err", {31'b0, resp_err}, 32'd1);
    chk("mis_rdata", resp_rdata, 32'd0);
    chk("mis_rd", {27'b0, resp_rd}, 32'd10);
`else
    chk("mis_rden", {31'b0, mem_rden}, 32'd1);
    @(negedge clk);
    chk("mis_rvalid_t2", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("mis_rvalid", {31'b0, resp_valid}, 32'd1);
    chk("mis_err", {31'b0, resp_err}, 32'd0);
    chk("mis_rd", {27'b0, resp_rd}, 32'd10);
`endif
    // reset during CAPTURE drops the in-flight load
    req(1'b0, 3'b010, 32'h104, 32'h0, 5'd11);
    @(negedge clk);
    @(negedge clk);
    chk("cap_rvalid", {31'b0, resp_valid}, 32'd0);
    #1 rstn = 1'b0;
    #1;
    chk("arst_rvalid", {31'b0, resp_valid}, 32'd0);
    chk("arst_strobes", {30'b0, mem_wren, mem_rden}, 32'd0);
    chk("arst_addr", mem_addr, 32'd0);
    chk("arst_data", mem_data, 32'd0);
    chk("arst_rwtyp", {29'b0, mem_rwtyp}, 32'd0);
    chk("arst_rd", {27'b0, resp_rd}, 32'd0);
    chk("arst_rdata", resp_rdata, 32'd0);
    chk("arst_err", {31'b0, resp_err}, 32'd0);
    chk("arst_req_ready", {31'b0, req_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_rvalid", {31'b0, resp_valid}, 32'd0);
      chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
    end
    store(3'b010, 32'h104, 32'h1234_5678, 5'd1);
    load(3'b001, 32'h104, 5'd2, 32'h0000_5678);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
